fsm4_tx: RTL and testbench
==========================

Name: fsm4_tx

Overview:
Serial transmitter that produces the single-bit stream consumed by the fsm4 two-bit history tracker. It accepts 2-bit symbols over a valid/ready interface and buffers them in a small FIFO. Each symbol is shifted out MSB first, one bit per clock, so that a downstream fsm4 sampling ser_out shows out == symbol after the second bit. Sits on the driving side of the fsm4 link in loopback and link-level benches.

Parameters:
FIFO_DEPTH, 4, symbol FIFO entries; power of two, minimum 2
IDLE_LVL, 0, level driven on ser_out when no symbol is in flight (0 or 1)
CNT_W, 16, width of the transmitted-symbol counter

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
sym_valid  input  1  upstream symbol valid
sym_data  input  2  symbol to send; bit 1 is sent first
sym_ready  output  1  FIFO can accept a symbol; equals !full
ser_out  output  1  registered serial bit toward the fsm4 in_sig
ser_active  output  1  high while ser_out carries a symbol bit
sym_done  output  1  one-cycle pulse in the cycle ser_out carries bit 0 of a symbol
sym_cnt  output  CNT_W  count of completed symbols; wraps modulo 2^CNT_W
fifo_level  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset (rst sampled high at a rising edge) sets:
  - ser_out = IDLE_LVL
  - ser_active = 0, sym_done = 0
  - sym_cnt = 0, fifo_level = 0
  - sym_ready = 1
  - FSM = IDLE, FIFO emptied
- Reset takes priority over all other activity. A symbol in flight is dropped mid-bit and never counted.
- Push: sym_valid && sym_ready at a rising edge writes sym_data into the FIFO.
  - sym_valid while full is ignored; no data is lost upstream because sym_ready = 0.
  - sym_ready depends only on registered FIFO state, never on sym_valid. There is no same-cycle pass-through.
- FSM states:
  - IDLE: ser_out = IDLE_LVL, ser_active = 0. If FIFO is non-empty, pop the head and go to BIT_HI. ser_out <= head[1] at that same edge.
  - BIT_HI: ser_out holds bit 1. Always go to BIT_LO, with ser_out <= held[0].
  - BIT_LO: ser_out holds bit 0, sym_done = 1, and sym_cnt increments at the edge leaving this state.
    - If FIFO is non-empty, pop and go to BIT_HI directly. Back-to-back symbols have no gap bit.
    - Otherwise go to IDLE.
- ser_out, ser_active and sym_done are all registered outputs.
- Latency: push at edge N with FIFO empty and FSM in IDLE gives:
  - ser_out = sym[1] during cycle N+1 to N+2
  - ser_out = sym[0] during cycle N+2 to N+3, with sym_done high in that cycle
- Throughput: one symbol per 2 cycles when fed continuously. With sym_valid held high, the FIFO fills after the upstream side outpaces the drain.
- Simultaneous push and pop in the same edge: both occur and fifo_level is unchanged. This is legal at any non-full level. When full, only the pop occurs and sym_ready rises the next cycle.
- FIFO pointers are $clog2(FIFO_DEPTH) bits and wrap naturally. Full/empty are derived from an occupancy counter.
- sym_cnt wraps from 2^CNT_W-1 to 0 with no saturation flag.
- Encoding in the FSM, IDLE never reached in BIT states: the default branch returns to IDLE with ser_out = IDLE_LVL.

Decomposition:
- Package fsm4_pkg holds:
  - sym_t (logic [1:0])
  - the 2-bit state encodings S0..S3 shared with fsm4
  - tx_state_t enum {TX_IDLE, TX_BIT_HI, TX_BIT_LO}
- One sub-module, fsm4_sym_fifo: synchronous FIFO parameterised on depth and width, with push/pop/full/empty/level.
- The top level holds the serializer FSM and the counter.

Test Plan:
- Reset, then push 2'b11 in one cycle → ser_out = 1 at N+1 and 1 at N+2. sym_done only at N+2. sym_cnt = 1. Back at IDLE_LVL at N+3.
- Loopback to fsm4 (rst_n = !rst), push sequence 2'b01, 2'b10, 2'b00, 2'b11 back-to-back → fsm4 out equals each symbol the cycle after its sym_done. ser_active stays high for 8 consecutive cycles. sym_cnt = 4.
- Hold sym_valid high with data incrementing mod 4 for 20 cycles, FIFO_DEPTH = 4 → sym_ready drops once fifo_level = 4. Accepted symbols are emitted in order with none duplicated or lost. Push and pop in the same edge leave fifo_level unchanged.
- Assert rst during BIT_HI of symbol 2'b10 → next cycle ser_out = IDLE_LVL, sym_cnt = 0, fifo_level = 0. The interrupted symbol is never emitted.
- CNT_W = 2, send 5 symbols → sym_cnt sequence 1, 2, 3, 0, 1.
- IDLE_LVL = 1, no traffic for 10 cycles → ser_out = 1 and ser_active = 0 throughout. Then push 2'b00 → ser_out = 0, 0, then returns to 1.

Source files
------------

// File: rtl/fsm4_pkg.sv
// -----------------------------------------------------------------------------
// fsm4_pkg
// Shared types for the fsm4 serial link.
//   sym_t         : 2-bit symbol carried over the link (bit 1 sent first)
//   fsm4_state_t  : 2-bit history encodings S0..S3 used by the fsm4 receiver
//   tx_state_t    : serializer states of fsm4_tx
// -----------------------------------------------------------------------------
package fsm4_pkg;

    typedef logic [1:0] sym_t;

    // Receiver history encodings; the value equals the last two bits seen,
    // older bit in the MSB, so a symbol lands as its own encoding.
    typedef enum logic [1:0] {
        S0 = 2'b00,
        S1 = 2'b01,
        S2 = 2'b10,
        S3 = 2'b11
    } fsm4_state_t;

    typedef enum logic [1:0] {
        TX_IDLE   = 2'b00,
        TX_BIT_HI = 2'b01,
        TX_BIT_LO = 2'b10
    } tx_state_t;

endpackage

// File: rtl/fsm4_sym_fifo.sv
// -----------------------------------------------------------------------------
// fsm4_sym_fifo
// Synchronous FIFO with an occupancy counter; full/empty derive from the
// counter, pointers wrap naturally at DEPTH (a power of two).
// Ports:
//   clk        in   rising-edge clock
//   rst        in   synchronous active-high reset (empties the FIFO)
//   push       in   write request; ignored while full
//   push_data  in   WIDTH-bit write data
//   pop        in   read request; ignored while empty
//   pop_data   out  head entry (valid while !empty)
//   full       out  occupancy == DEPTH
//   empty      out  occupancy == 0
//   level      out  current occupancy
// -----------------------------------------------------------------------------
module fsm4_sym_fifo #(
    parameter  int DEPTH = 4,
    parameter  int WIDTH = 2,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int LVL_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty,
    output logic [LVL_W-1:0] level
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [LVL_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == LVL_W'(DEPTH));
    assign empty    = (count == '0);
    assign level    = count;
    assign pop_data = mem[rd_ptr];

    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of block evaluation order.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // NOTE: storage is deliberately not reset; entries are only read after
    // being written, and leaving reset off lets the array map to plain RAM.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/fsm4_tx.sv
// -----------------------------------------------------------------------------
// fsm4_tx
// Serial transmitter feeding the fsm4 history tracker. Symbols enter through a
// valid/ready FIFO and leave MSB first, one bit per clock, with no gap between
// back-to-back symbols.
// Ports:
//   clk         in   rising-edge clock
//   rst         in   synchronous active-high reset
//   sym_valid   in   upstream symbol valid
//   sym_data    in   symbol to send (bit 1 first)
//   sym_ready   out  FIFO not full
//   ser_out     out  registered serial bit (IDLE_LVL between symbols)
//   ser_active  out  high while ser_out carries a symbol bit
//   sym_done    out  high in the cycle ser_out carries bit 0
//   sym_cnt     out  completed-symbol count, wraps
//   fifo_level  out  FIFO occupancy
// -----------------------------------------------------------------------------
module fsm4_tx
    import fsm4_pkg::*;
#(
    parameter int   FIFO_DEPTH = 4,
    parameter logic IDLE_LVL   = 1'b0,
    parameter int   CNT_W      = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         sym_valid,
    input  sym_t                         sym_data,
    output logic                         sym_ready,
    output logic                         ser_out,
    output logic                         ser_active,
    output logic                         sym_done,
    output logic [CNT_W-1:0]             sym_cnt,
    output logic [$clog2(FIFO_DEPTH):0]  fifo_level
);

    tx_state_t state, state_nxt;
    logic      lo_bit, lo_bit_nxt;     // bit 0 of the symbol in flight
    logic      ser_nxt, active_nxt, done_nxt;
    logic      pop;
    logic      full, empty;
    sym_t      head;

    fsm4_sym_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH ($bits(sym_t))
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (sym_valid),
        .push_data (sym_data),
        .pop       (pop),
        .pop_data  (head),
        .full      (full),
        .empty     (empty),
        .level     (fifo_level)
    );

    // Depends on registered FIFO state only: no combinational path from
    // sym_valid to sym_ready.
    assign sym_ready = !full;

    // NOTE: every always_comb output gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    always_comb begin
        state_nxt  = state;
        lo_bit_nxt = lo_bit;
        ser_nxt    = IDLE_LVL;
        active_nxt = 1'b0;
        done_nxt   = 1'b0;
        pop        = 1'b0;

        case (state)
            TX_IDLE: begin
                if (!empty) begin
                    pop        = 1'b1;
                    lo_bit_nxt = head[0];
                    ser_nxt    = head[1];
                    active_nxt = 1'b1;
                    state_nxt  = TX_BIT_HI;
                end
            end
            TX_BIT_HI: begin
                ser_nxt    = lo_bit;
                active_nxt = 1'b1;
                done_nxt   = 1'b1;
                state_nxt  = TX_BIT_LO;
            end
            TX_BIT_LO: begin
                // Chain straight into the next symbol to avoid a gap bit.
                if (!empty) begin
                    pop        = 1'b1;
                    lo_bit_nxt = head[0];
                    ser_nxt    = head[1];
                    active_nxt = 1'b1;
                    state_nxt  = TX_BIT_HI;
                end else begin
                    state_nxt  = TX_IDLE;
                end
            end
            default: begin
                state_nxt = TX_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= TX_IDLE;
            lo_bit     <= 1'b0;
            ser_out    <= IDLE_LVL;
            ser_active <= 1'b0;
            sym_done   <= 1'b0;
            sym_cnt    <= '0;
        end else begin
            state      <= state_nxt;
            lo_bit     <= lo_bit_nxt;
            ser_out    <= ser_nxt;
            ser_active <= active_nxt;
            sym_done   <= done_nxt;
            // The symbol completes on the edge that leaves BIT_LO.
            if (state == TX_BIT_LO) sym_cnt <= sym_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_fsm4_tx.sv
// -----------------------------------------------------------------------------
// tb_fsm4_tx
// Directed bench for fsm4_tx. u_dut uses default parameters and is watched by
// a scoreboard plus a two-bit history model standing in for the fsm4 receiver;
// u_dut2 uses CNT_W = 2 and IDLE_LVL = 1.
// -----------------------------------------------------------------------------
module tb_fsm4_tx;
    import fsm4_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        valid, valid2;
    sym_t        data, data2;

    logic        ready, ser, active, done;
    logic [15:0] cnt;
    logic [2:0]  level;

    logic        ready2, ser2, active2, done2;
    logic [1:0]  cnt2;
    logic [2:0]  level2;

    fsm4_tx u_dut (
        .clk        (clk),
        .rst        (rst),
        .sym_valid  (valid),
        .sym_data   (data),
        .sym_ready  (ready),
        .ser_out    (ser),
        .ser_active (active),
        .sym_done   (done),
        .sym_cnt    (cnt),
        .fifo_level (level)
    );

    fsm4_tx #(
        .FIFO_DEPTH (4),
        .IDLE_LVL   (1'b1),
        .CNT_W      (2)
    ) u_dut2 (
        .clk        (clk),
        .rst        (rst),
        .sym_valid  (valid2),
        .sym_data   (data2),
        .sym_ready  (ready2),
        .ser_out    (ser2),
        .ser_active (active2),
        .sym_done   (done2),
        .sym_cnt    (cnt2),
        .fifo_level (level2)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst    = 1'b1;
        valid  = 1'b0;
        valid2 = 1'b0;
        step();
        step();
        rst    = 1'b0;
    endtask

    // Scoreboard of accepted symbols and a receiver-side history register.
    sym_t sb_q[$];
    int   n_acc  = 0;
    int   n_emit = 0;
    logic [1:0] hist = 2'b00;

    always @(posedge clk) begin
        sym_t e;
        if (rst) begin
            sb_q.delete();
        end else begin
            if (done) begin
                if (sb_q.size() == 0) begin
                    check("sb_underflow", 32'd1, 32'd0);
                end else begin
                    e = sb_q.pop_front();
                    // Receiver output the cycle after sym_done.
                    check("loopback_out", {30'd0, hist[0], ser}, {30'd0, e});
                    n_emit++;
                end
            end
            if (valid && ready) begin
                sb_q.push_back(data);
                n_acc++;
            end
        end
        hist = {hist[0], ser};
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    int exp_seq[5] = '{1, 2, 3, 0, 1};

    initial begin
        int run, max_run, exp_lvl, acc0, emit0, idx;
        logic [1:0] last;

        rst = 1'b1; valid = 1'b0; valid2 = 1'b0; data = '0; data2 = '0;
        do_reset();

        // ---- reset state ----
        check("rst_ser",    ser,    0);
        check("rst_active", active, 0);
        check("rst_done",   done,   0);
        check("rst_cnt",    cnt,    0);
        check("rst_level",  level,  0);
        check("rst_ready",  ready,  1);
        check("rst_ser2",   ser2,   1);
        check("rst_cnt2",   cnt2,   0);

        // ---- IDLE_LVL = 1: quiet line, then one 2'b00 symbol ----
        for (int i = 0; i < 10; i++) begin
            step();
            check("idle_ser2",    ser2,    1);
            check("idle_active2", active2, 0);
        end
        valid2 = 1'b1; data2 = 2'b00;
        step();
        valid2 = 1'b0;
        check("hi_idle_n0", ser2, 1);
        step();
        check("hi_idle_n1",   ser2,    0);
        check("hi_idle_act1", active2, 1);
        step();
        check("hi_idle_n2",   ser2,  0);
        check("hi_idle_done", done2, 1);
        step();
        check("hi_idle_n3",   ser2,    1);
        check("hi_idle_act3", active2, 0);

        // ---- CNT_W = 2 wrap: five symbols ----
        do_reset();
        last = 2'b00;
        idx  = 0;
        for (int i = 0; i < 35; i++) begin
            valid2 = (i < 5);
            data2  = sym_t'(i[1:0]);
            step();
            if (cnt2 != last) begin
                if (idx < 5) check("wrap_cnt", cnt2, exp_seq[idx]);
                else         check("wrap_extra", 32'd1, 32'd0);
                idx++;
                last = cnt2;
            end
        end
        valid2 = 1'b0;
        check("wrap_count_changes", idx, 5);

        // ---- single symbol 2'b11, latency ----
        do_reset();
        valid = 1'b1; data = 2'b11;
        step();                                   // edge N
        valid = 1'b0;
        check("lat_n_ser",   ser,   0);
        check("lat_n_level", level, 1);
        step();                                   // edge N+1
        check("lat_n1_ser",    ser,    1);
        check("lat_n1_active", active, 1);
        check("lat_n1_done",   done,   0);
        step();                                   // edge N+2
        check("lat_n2_ser",  ser,  1);
        check("lat_n2_done", done, 1);
        check("lat_n2_cnt",  cnt,  0);
        step();                                   // edge N+3
        check("lat_n3_ser",    ser,    0);
        check("lat_n3_done",   done,   0);
        check("lat_n3_active", active, 0);
        check("lat_n3_cnt",    cnt,    1);

        // ---- back-to-back loopback: 01, 10, 00, 11 ----
        do_reset();
        run = 0; max_run = 0;
        for (int i = 0; i < 16; i++) begin
            valid = (i < 4);
            case (i)
                0:       data = 2'b01;
                1:       data = 2'b10;
                2:       data = 2'b00;
                default: data = 2'b11;
            endcase
            step();
            if (active) run++;
            else        run = 0;
            if (run > max_run) max_run = run;
        end
        valid = 1'b0;
        check("b2b_active_run", max_run, 8);
        check("b2b_cnt",        cnt,     4);
        check("b2b_sb_empty",   sb_q.size(), 0);

        // ---- continuous feed, FIFO fills ----
        do_reset();
        acc0  = n_acc;
        emit0 = n_emit;
        for (int k = 1; k <= 20; k++) begin
            valid = 1'b1;
            data  = sym_t'(k[1:0]);
            step();
            exp_lvl = (k <= 6) ? (k + 1) / 2 : ((k % 2 == 1) ? 4 : 3);
            check("fill_level", level, exp_lvl);
            check("fill_ready", ready, (exp_lvl != 4) ? 1 : 0);
        end
        valid = 1'b0;
        for (int i = 0; i < 30 && (level != 0 || active); i++) step();
        check("drain_done",  (level == 0 && !active) ? 1 : 0, 1);
        check("fill_acc",    n_acc - acc0,   13);
        check("fill_emit",   n_emit - emit0, 13);
        check("fill_sb",     sb_q.size(),    0);
        check("fill_cnt",    cnt,            13);

        // ---- reset during BIT_HI of 2'b10 ----
        valid = 1'b1; data = 2'b10;
        step();                                   // pushed
        data = 2'b01;
        step();                                   // 2'b10 popped, now BIT_HI
        check("mid_ser_hi", ser,    1);
        check("mid_active", active, 1);
        check("mid_level",  level,  1);
        rst = 1'b1; data = 2'b11;
        step();
        rst = 1'b0; valid = 1'b0;
        check("mid_rst_ser",    ser,    0);
        check("mid_rst_active", active, 0);
        check("mid_rst_cnt",    cnt,    0);
        check("mid_rst_level",  level,  0);
        check("mid_rst_ready",  ready,  1);
        for (int i = 0; i < 4; i++) begin
            step();
            check("mid_no_emit", {30'd0, done, active}, 0);
        end
        check("mid_cnt_after", cnt, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
